// File: rtl/cell_sweep_ctrl.sv
// cell_sweep_ctrl: exhaustive truth-table sweep of one combinational cell; SWEEP_OBSERVED_EN keeps a per-vector capture
module cell_sweep_ctrl #(
   parameter int N_IN = 3,
   parameter int SETTLE = 10,
   parameter logic [2**N_IN-1:0] EXPECT = 8'h1F
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic [N_IN-1:0]      cell_in,
   input  logic                 cell_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic [N_IN-1:0]      first_fail,
   output logic                 first_fail_vld,
   output logic [2**N_IN-1:0]   observed
);
   localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
   state_t state;
   logic [N_IN-1:0] vec;
   logic [SW-1:0] settle;
   logic mis;
   logic take;
   assign mis = cell_out != EXPECT[vec];
   assign take = state == IDLE && start && !abort;
   // sweep sequencer: vector stepping, settle timing, mismatch bookkeeping
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         vec <= '0;
         settle <= '0;
         cell_in <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         err_cnt <= '0;
         first_fail <= '0;
         first_fail_vld <= 1'b0;
      end else if (abort && state != IDLE) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         cell_in <= '0;
         pass <= 1'b0;
      end else
         case (state)
            IDLE: if (take) begin
               state <= WAIT;
               vec <= '0;
               cell_in <= '0;
               settle <= SW'(SETTLE - 1);
               err_cnt <= '0;
               first_fail <= '0;
               first_fail_vld <= 1'b0;
               pass <= 1'b0;
               busy <= 1'b1;
            end
            WAIT: if (settle == '0) state <= SAMPLE;
               else settle <= settle - 1'b1;
            SAMPLE: begin
               err_cnt <= err_cnt + {{N_IN{1'b0}}, mis};
               if (mis && !first_fail_vld) begin
                  first_fail <= vec;
                  first_fail_vld <= 1'b1;
               end
               if (&vec) begin
                  state <= DONE;
                  done <= 1'b1;
                  busy <= 1'b0;
                  cell_in <= '0;
                  pass <= err_cnt == '0 && !mis;
               end else begin
                  state <= WAIT;
                  vec <= vec + 1'b1;
                  cell_in <= vec + 1'b1;
                  settle <= SW'(SETTLE - 1);
               end
            end
            DONE: begin
               state <= IDLE;
               done <= 1'b0;
            end
         endcase
`ifdef SWEEP_OBSERVED_EN
   // per-vector capture of the sampled cell output, cleared when a sweep starts
   always_ff @(posedge clk or posedge rst)
      if (rst) observed <= '0;
      else if (take) observed <= '0;
      else if (state == SAMPLE && !abort) observed[vec] <= cell_out;
`else
   assign observed = '0;
`endif
endmodule
